// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame engine:
// FSM state encoding, FIFO entry field positions and the parity helper.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    PARITY   = 3'd3,
    STOP     = 3'd4,
    BRK_WAIT = 3'd5
  } rx_state_e;

  localparam int ENTRY_W      = 12;
  localparam int OE_IDX       = 11;
  localparam int BE_IDX       = 10;
  localparam int PE_IDX       = 9;
  localparam int FE_IDX       = 8;
  localparam int TIMEOUT_BITS = 32;

  // Unused high data bits are zero, so XOR over all eight bits is exact.
  function automatic logic parity_expected(input logic [7:0] data,
                                           input logic eps,
                                           input logic sps);
    if (sps) return ~eps;
    return eps ? ^data : ~^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO with level/full/empty. i_wr_en and i_rd_en are
// already qualified by the caller: write only when not full or popping, read only when not empty.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1,
  parameter int W     = 12
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [W-1:0]     i_wr_data,
  input  logic             i_rd_en,
  output logic [W-1:0]     o_rd_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [LVL_W-1:0] o_level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [LVL_W-1:0] r_level;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_wr_en) r_wptr <= r_wptr + 1'b1;
      if (i_rd_en) r_rptr <= r_rptr + 1'b1;
      case ({i_wr_en, i_rd_en})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_empty   = (r_level == '0);
  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_level   = r_level;
  // Gate with empty so the head reads zero after reset and when drained.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/uart_rx_frame_engine.sv
// UART receive path: synchroniser, oversample tick, frame FSM, break/overrun
// tagging, level and timeout interrupts, feeding a 12-bit FWFT FIFO.
module uart_rx_frame_engine
  import uart_rx_pkg::*;
#(
  parameter int OVS   = 16,
  parameter int DIV_W = 16,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_wlen,
  input  logic             cfg_pen,
  input  logic             cfg_eps,
  input  logic             cfg_sps,
  input  logic [LVL_W-1:0] cfg_ifls,
  input  logic             rxd,
  input  logic             rd_en,
  output logic [11:0]      rd_data,
  output logic             rx_empty,
  output logic             rx_full,
  output logic [LVL_W-1:0] rx_level,
  output logic             rx_intr,
  output logic             rt_intr,
  output rx_state_e        dbg_state
);
  localparam int SC_W     = $clog2(OVS);
  localparam int TO_LIMIT = TIMEOUT_BITS * OVS;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  logic             r_sync1, r_sync2, w_rxs;
  logic [DIV_W-1:0] r_div_cnt;
  logic             w_tick;
  rx_state_e        r_state, w_state_nxt;
  logic [SC_W-1:0]  r_samp_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_par_bit;
  logic             r_push_pend;
  logic [10:0]      r_push_entry;
  logic             r_oe;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_rx_intr;
  logic             w_mid_start, w_mid_bit, w_last_bit, w_break, w_stop_done, w_pe;
  logic             w_pop, w_push_ok, w_overrun;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end
  assign w_rxs = r_sync2;

  always_ff @(posedge PCLK) begin
    if (!PRESETn)    r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= cfg_div;
    else             r_div_cnt <= r_div_cnt - 1'b1;
  end
  assign w_tick = (r_div_cnt == '0);

  assign w_mid_start = (r_samp_cnt == SC_W'(OVS/2 - 1));
  assign w_mid_bit   = (r_samp_cnt == SC_W'(OVS - 1));
  assign w_last_bit  = (r_bit_cnt == (3'(cfg_wlen) + 3'd4));
  assign w_break     = !w_rxs && (r_shift == '0) && (!cfg_pen || !r_par_bit);
  assign w_stop_done = cfg_en && w_tick && (r_state == STOP) && w_mid_bit;
  assign w_pe        = cfg_pen && (r_par_bit != parity_expected(r_shift, cfg_eps, cfg_sps));

  always_comb begin
    w_state_nxt = r_state;
    if (!cfg_en) begin
      w_state_nxt = IDLE;
    end else if (w_tick) begin
      case (r_state)
        IDLE:     if (!w_rxs) w_state_nxt = START;
        START:    if (w_mid_start) w_state_nxt = w_rxs ? IDLE : DATA;
        DATA:     if (w_mid_bit && w_last_bit) w_state_nxt = cfg_pen ? PARITY : STOP;
        PARITY:   if (w_mid_bit) w_state_nxt = STOP;
        STOP:     if (w_mid_bit) w_state_nxt = w_break ? BRK_WAIT : IDLE;
        BRK_WAIT: if (w_rxs) w_state_nxt = IDLE;
        default:  w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state      <= IDLE;
      r_samp_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_push_pend  <= 1'b0;
      r_push_entry <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_push_pend <= w_stop_done;
      if (w_stop_done)
        r_push_entry <= w_break ? 11'h500 : {1'b0, w_pe, !w_rxs, r_shift};
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            r_samp_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
          end
          START: r_samp_cnt <= w_mid_start ? '0 : r_samp_cnt + 1'b1;
          DATA, PARITY, STOP: begin
            if (w_mid_bit) begin
              r_samp_cnt <= '0;
              if (r_state == DATA) begin
                r_shift[r_bit_cnt] <= w_rxs;
                r_bit_cnt          <= r_bit_cnt + 1'b1;
              end
              if (r_state == PARITY) r_par_bit <= w_rxs;
            end else begin
              r_samp_cnt <= r_samp_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A push into a full FIFO is accepted only if the same cycle pops.
  assign w_pop     = rd_en && !rx_empty;
  assign w_push_ok = r_push_pend && (!rx_full || w_pop);
  assign w_overrun = r_push_pend && rx_full && !w_pop;

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_oe      <= 1'b0;
      r_to_cnt  <= '0;
      r_rx_intr <= 1'b0;
    end else begin
      if (w_overrun)      r_oe <= 1'b1;
      else if (w_push_ok) r_oe <= 1'b0;
      if (w_push_ok || w_pop || rx_empty)
        r_to_cnt <= '0;
      else if (w_tick && (r_state == IDLE) && (r_to_cnt < TO_W'(TO_LIMIT)))
        r_to_cnt <= r_to_cnt + 1'b1;
      r_rx_intr <= (cfg_ifls != '0) && (rx_level >= cfg_ifls);
    end
  end

  uart_rx_fifo #(.DEPTH(DEPTH), .LVL_W(LVL_W), .W(ENTRY_W)) u_fifo (
    .i_clk     (PCLK),
    .i_rst_n   (PRESETn),
    .i_wr_en   (w_push_ok),
    .i_wr_data ({r_oe, r_push_entry}),
    .i_rd_en   (w_pop),
    .o_rd_data (rd_data),
    .o_empty   (rx_empty),
    .o_full    (rx_full),
    .o_level   (rx_level)
  );

  assign rx_intr   = r_rx_intr;
  assign rt_intr   = (r_to_cnt == TO_W'(TO_LIMIT));
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Directed bench for uart_rx_frame_engine with a 4-entry FIFO, OVS=16, divisor 3
// (64 PCLK per bit): framing, parity, break, overrun, false start and interrupts.
module tb_uart_rx_frame_engine;
  import uart_rx_pkg::*;

  localparam int OVS     = 16;
  localparam int DIV_W   = 16;
  localparam int DEPTH   = 4;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int BIT_CYC = 64;

  logic             PCLK = 1'b0;
  logic             PRESETn;
  logic             cfg_en;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_wlen;
  logic             cfg_pen, cfg_eps, cfg_sps;
  logic [LVL_W-1:0] cfg_ifls;
  logic             rxd;
  logic             rd_en;
  logic [11:0]      rd_data;
  logic             rx_empty, rx_full, rx_intr, rt_intr;
  logic [LVL_W-1:0] rx_level;
  rx_state_e        dbg_state;

  int n_pass = 0;
  int n_checks = 0;

  uart_rx_frame_engine #(.OVS(OVS), .DIV_W(DIV_W), .DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .cfg_en(cfg_en), .cfg_div(cfg_div),
    .cfg_wlen(cfg_wlen), .cfg_pen(cfg_pen), .cfg_eps(cfg_eps), .cfg_sps(cfg_sps),
    .cfg_ifls(cfg_ifls), .rxd(rxd), .rd_en(rd_en), .rd_data(rd_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_level(rx_level),
    .rx_intr(rx_intr), .rt_intr(rt_intr), .dbg_state(dbg_state)
  );

  // Clock and reset-time defaults
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BIT_CYC) @(negedge PCLK);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits,
                            input logic use_par, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(data[i]);
    if (use_par) drive_bit(par_bit);
    drive_bit(1'b1);
    repeat (BIT_CYC) @(negedge PCLK);
  endtask

  task automatic pop_check(input string tag, input logic [11:0] exp);
    check(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(negedge PCLK);
    rd_en = 1'b0;
  endtask

  initial begin
    logic par_ok;
    bit   seen;

    PRESETn = 1'b0; cfg_en = 1'b1; cfg_div = 16'd3; cfg_wlen = 2'd3;
    cfg_pen = 1'b0; cfg_eps = 1'b0; cfg_sps = 1'b0; cfg_ifls = '0;
    rxd = 1'b1; rd_en = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_empty",   32'(rx_empty), 32'd1);
    check("rst_full",    32'(rx_full), 32'd0);
    check("rst_level",   32'(rx_level), 32'd0);
    check("rst_rx_intr", 32'(rx_intr), 32'd0);
    check("rst_rt_intr", 32'(rt_intr), 32'd0);
    check("rst_state",   32'(dbg_state), 32'(IDLE));
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0);
    check("a5_level", 32'(rx_level), 32'd1);
    pop_check("a5_data", 12'h0A5);
    check("a5_empty", 32'(rx_empty), 32'd1);

    // 6-bit odd parity, wrong parity bit: 0x2B has four ones, correct bit is 1
    cfg_wlen = 2'd1; cfg_pen = 1'b1; cfg_eps = 1'b0;
    par_ok = 1'b1;
    send_frame(8'h2B, 6, 1'b1, ~par_ok);
    pop_check("par_err", 12'h22B);

    // 8-bit even parity, correct bit: 0x15 has three ones -> parity 1
    cfg_wlen = 2'd3; cfg_eps = 1'b1;
    send_frame(8'h15, 8, 1'b1, 1'b1);
    pop_check("par_even_ok", 12'h015);

    // Stick parity with eps=0 expects a 1 regardless of data
    cfg_sps = 1'b1; cfg_eps = 1'b0;
    send_frame(8'h81, 8, 1'b1, 1'b1);
    pop_check("par_stick_ok", 12'h081);
    cfg_sps = 1'b0; cfg_pen = 1'b0;

    // Break: line low for 12 bit times
    rxd = 1'b0;
    repeat (12 * BIT_CYC) @(negedge PCLK);
    check("brk_state_wait", 32'(dbg_state), 32'(BRK_WAIT));
    check("brk_level", 32'(rx_level), 32'd1);
    rxd = 1'b1;
    repeat (BIT_CYC) @(negedge PCLK);
    check("brk_state_idle", 32'(dbg_state), 32'(IDLE));
    check("brk_level_after", 32'(rx_level), 32'd1);
    pop_check("brk_entry", 12'h500);

    // Overrun: 01..04 fill, 05 is dropped, 06 after one pop carries OE
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, 1'b0, 1'b0);
    check("ovr_full", 32'(rx_full), 32'd1);
    send_frame(8'h05, 8, 1'b0, 1'b0);
    check("ovr_level", 32'(rx_level), 32'd4);
    pop_check("ovr_e1", 12'h001);
    send_frame(8'h06, 8, 1'b0, 1'b0);
    pop_check("ovr_e2", 12'h002);
    pop_check("ovr_e3", 12'h003);
    pop_check("ovr_e4", 12'h004);
    pop_check("ovr_oe", 12'h806);
    check("ovr_empty", 32'(rx_empty), 32'd1);

    // False start: 3 ticks low
    rxd = 1'b0;
    repeat (12) @(negedge PCLK);
    rxd = 1'b1;
    repeat (BIT_CYC) @(negedge PCLK);
    check("fs_state", 32'(dbg_state), 32'(IDLE));
    check("fs_level", 32'(rx_level), 32'd0);

    // Receiver disabled: frame ignored
    cfg_en = 1'b0;
    send_frame(8'h55, 8, 1'b0, 1'b0);
    check("dis_level", 32'(rx_level), 32'd0);
    check("dis_state", 32'(dbg_state), 32'(IDLE));
    cfg_en = 1'b1;
    repeat (BIT_CYC) @(negedge PCLK);

    // Timeout: 512 ticks (2048 PCLK) after the push, which is ~93 PCLK before send returns
    send_frame(8'h3C, 8, 1'b0, 1'b0);
    repeat (1800) @(negedge PCLK);
    check("to_early", 32'(rt_intr), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge PCLK);
      seen = rt_intr;
    end
    check("to_rise", 32'(seen), 32'd1);
    pop_check("to_data", 12'h03C);
    check("to_clear", 32'(rt_intr), 32'd0);

    // Level interrupt at threshold 2
    cfg_ifls = 3'd2;
    send_frame(8'h11, 8, 1'b0, 1'b0);
    check("ifls_one", 32'(rx_intr), 32'd0);
    send_frame(8'h22, 8, 1'b0, 1'b0);
    check("ifls_two", 32'(rx_intr), 32'd1);
    pop_check("ifls_d1", 12'h011);
    @(negedge PCLK);
    check("ifls_drop", 32'(rx_intr), 32'd0);
    pop_check("ifls_d2", 12'h022);
    check("end_empty", 32'(rx_empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_engine.md
Name: uart_rx_frame_engine

Overview:
- Parametrised, synthesisable UART receive path for the next-generation UART.
- Generalises the fixed 8-bit receive path: 5–8 data bits, none/even/odd/stick parity, programmable oversampling divisor, configurable FIFO depth.
- Adds break detection, overrun tagging, threshold RX interrupt and receive-timeout interrupt.
- Sits between the RX pad synchroniser and the APB register block; the register block drives the cfg_* inputs and pops the FIFO on data-register reads.

Parameters:
- OVS, 16, oversampling ticks per bit (even, ≥8).
- DIV_W, 16, width of baud divisor.
- DEPTH, 16, RX FIFO entries (power of 2, ≥2).
- LVL_W, $clog2(DEPTH)+1, width of level/threshold fields.

Ports:
- PCLK  in  1  sole clock.
- PRESETn  in  1  reset, synchronous and active-low.
- cfg_en  in  1  receiver enable.
- cfg_div  in  DIV_W  oversample tick every cfg_div+1 PCLK cycles.
- cfg_wlen  in  2  word length: 0=5, 1=6, 2=7, 3=8 bits.
- cfg_pen  in  1  parity enable.
- cfg_eps  in  1  even parity select.
- cfg_sps  in  1  stick parity.
- cfg_ifls  in  LVL_W  RX interrupt threshold; 0 disables.
- rxd  in  1  asynchronous serial input, idle high.
- rd_en  in  1  pop request, one entry per cycle.
- rd_data  out  12  {OE,BE,PE,FE,data[7:0]} head entry; unused data bits 0.
- rx_empty  out  1  FIFO empty.
- rx_full  out  1  FIFO full.
- rx_level  out  LVL_W  current entry count.
- rx_intr  out  1  level threshold interrupt.
- rt_intr  out  1  receive timeout interrupt.

Behaviour:
- Reset (PRESETn low at a PCLK edge):
  - state IDLE, FIFO empty, sticky overrun clear, divisor and timeout counters 0, synchroniser flops 1.
  - Outputs: rd_data 0, rx_empty 1, rx_full 0, rx_level 0, rx_intr 0, rt_intr 0.
  - Reset mid-frame discards the partial frame.
- rxd passes through a 2-flop synchroniser; all logic uses the synchronised value rxs.
- Tick generator: a counter reloads at cfg_div and asserts tick for one cycle on reaching 0. cfg_div=0 gives a tick every cycle.
- Receiver FSM, advancing only on tick:
  - IDLE → START when rxs=0 (sample count cleared).
  - START: at sample OVS/2-1, if rxs=1 it is a false start → IDLE; else → DATA.
  - DATA: sample each bit at mid-bit (every OVS ticks), LSB first. After wlen+5 bits → PARITY if cfg_pen, else STOP.
  - PARITY: sample one bit → STOP.
  - STOP: sample one bit; push the entry on the next cycle; → BRK_WAIT if break, else IDLE.
  - BRK_WAIT → IDLE once rxs=1.
- Only the first stop bit is checked; a second stop bit is treated as idle.
- Parity expected value:
  - sps=0, eps=1: parity bit = XOR(data).
  - sps=0, eps=0: parity bit = ~XOR(data).
  - sps=1: parity bit = ~eps.
  - PE=1 on mismatch.
- FE=1 if the stop sample is 0.
- Break: all data bits, parity (if enabled) and stop bit are 0 → push one entry with BE=1, FE=1, PE=0, data=0.
- cfg_en low: FSM forced to IDLE within one cycle; FIFO contents kept; the tick generator keeps running.
- FIFO behaviour:
  - First-word fall-through: rd_data reflects the head combinationally.
  - Pop on rd_en && !rx_empty; rd_en while empty is ignored.
  - Push and pop in the same cycle: level unchanged, no overrun, even when full.
- Overrun: a push while full and not popping discards the frame and sets a sticky oe flag. The next successful push carries OE=1 and clears oe.
- rx_intr = (cfg_ifls != 0) && (rx_level >= cfg_ifls), registered, 1-cycle latency.
- Timeout:
  - The counter runs on tick while the FIFO is non-empty and the FSM is in IDLE.
  - The counter clears on push, pop, or the FIFO going empty.
  - rt_intr asserts when the count reaches 32*OVS and holds until the counter clears.

Decomposition:
- Package uart_rx_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP, BRK_WAIT), entry field indices (OE=11, BE=10, PE=9, FE=8), timeout constant 32.
- Sub-module uart_rx_fifo (DEPTH × 12-bit FWFT FIFO with level, full, empty); the FSM, tick generator and flags stay in the top module.

Test Plan:
- cfg_div=3, 8N1, send 0xA5 → after ~10*64 PCLK, rx_level=1, rd_data=0x0A5; rd_en pulse → rx_empty=1.
- wlen=1 (6 bits), pen=1, eps=0, send 0x2B with a wrong parity bit → rd_data=0x22B (PE set, data 0x2B).
- Hold rxd low for 12 bit times, then high → exactly one entry 0x500 (BE, FE set); FSM returns to IDLE only after rxd goes high.
- DEPTH=4: send 5 frames 0x01..0x05 without reads, then 0x06 → FIFO holds 01..04, rx_full=1. After one pop, the next entry pushed is 0x806 (OE set).
- rxd low pulse shorter than OVS/2 ticks → no entry, FSM back in IDLE, rx_level=0.
- One byte received, no reads → rt_intr rises after 32*16 ticks; rd_en pop → rt_intr=0 next cycle. Also check cfg_ifls=2: rx_intr=1 only after the 2nd byte.
